// File: rtl/pluck_profile_writer.sv
// Writes a triangular pluck profile into the node-displacement memory, one node per
// accepted beat, using an add/subtract accumulator instead of a ROM or multiplier.
module pluck_profile_writer #(
  parameter int                N_NODES   = 30,
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 18,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [DATA_W-1:0] STEP      = 18'h00924,
  parameter logic [DATA_W-1:0] PEAK      = 18'h08000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam int H  = N_NODES / 2;
  localparam int IW = $clog2(N_NODES);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_NODES - 1);
  localparam logic [IW-1:0] CTR_LO   = IW'(H - 1);
  localparam logic [IW-1:0] CTR_HI   = IW'(H);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t              state_reg, state_next;
  logic [IW-1:0]       i_reg, i_next;
  logic [DATA_W-1:0]   acc_reg, acc_next;
  logic                wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
  logic [DATA_W-1:0]   wr_data_reg, wr_data_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      i_reg       <= '0;
      acc_reg     <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= BASE_ADDR;
      wr_data_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      i_reg       <= i_next;
      acc_reg     <= acc_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  // Outputs are computed one cycle ahead so the beat for the next node is
  // already registered when the current one is accepted.
  always_comb begin
    state_next   = state_reg;
    i_next       = i_reg;
    acc_next     = acc_reg;
    wr_en_next   = wr_en_reg;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = WRITE;
          i_next       = '0;
          acc_next     = '0;
          wr_en_next   = 1'b1;
          busy_next    = 1'b1;
          wr_addr_next = BASE_ADDR;
          wr_data_next = '0;
        end
      end

      WRITE: begin
        if (wr_ready) begin
          if (i_reg == LAST_IDX) begin
            state_next   = DONE;
            wr_en_next   = 1'b0;
            busy_next    = 1'b0;
            done_next    = 1'b1;
            wr_addr_next = BASE_ADDR;
            wr_data_next = '0;
          end else begin
            i_next = i_reg + 1'b1;
            // Rising slope up to the node before the centre pair, flat across it, then falling.
            if (i_reg < CTR_LO)
              acc_next = acc_reg + STEP;
            else if (i_reg == CTR_LO)
              acc_next = acc_reg;
            else
              acc_next = acc_reg - STEP;
            wr_addr_next = BASE_ADDR + ADDR_W'(i_next);
            wr_data_next = (i_next == CTR_LO || i_next == CTR_HI) ? PEAK : acc_next;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_pluck_profile_writer.sv
// Self-checking bench for pluck_profile_writer: transaction-level shadow model checked
// every cycle, plus literal expectations for the default profile and a 4-node instance.
module tb_pluck_profile_writer;

  localparam int N = 30;
  localparam logic [9:0] BASE = 10'h000;

  logic        clk = 1'b0;
  logic        reset, start, wr_ready;
  logic        wr_en, busy, done;
  logic [9:0]  wr_addr;
  logic [17:0] wr_data;

  logic        start4, ready4;
  logic        wr_en4, busy4, done4;
  logic [9:0]  wr_addr4;
  logic [17:0] wr_data4;

  always #5 clk = ~clk;

  pluck_profile_writer dut (
    .clk(clk), .reset(reset), .start(start), .wr_ready(wr_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  pluck_profile_writer #(
    .N_NODES(4), .ADDR_W(10), .DATA_W(18), .BASE_ADDR(10'h100),
    .STEP(18'h01000), .PEAK(18'h08000)
  ) dut4 (
    .clk(clk), .reset(reset), .start(start4), .wr_ready(ready4),
    .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4), .busy(busy4), .done(done4)
  );

  int cmp_count = 0;
  int err_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Profile straight from its definition: centre pair at peak, else distance-to-edge times step.
  function automatic logic [17:0] profile(input int i);
    int k;
    if (i == N/2 - 1 || i == N/2) return 18'h08000;
    k = (i < N - 1 - i) ? i : N - 1 - i;
    return 18'(k * 32'h924);
  endfunction

  // Shadow model state, advanced once per cycle from the inputs seen at the previous edge.
  logic        prev_reset = 1'b1, prev_start = 1'b0, prev_ready = 1'b0;
  bit          m_active = 0, m_done = 0;
  int          m_idx = 0;
  int          cyc = 0, start_neg = 0, done_neg = 0;
  int          acc_cnt = 0, done_cnt = 0;
  logic [17:0] cap [N];

  always @(negedge clk) begin
    cyc++;
    if (prev_reset) begin
      m_active = 0; m_done = 0; m_idx = 0;
    end else if (m_active) begin
      if (prev_ready) begin
        if (m_idx == N - 1) begin
          m_active = 0; m_done = 1;
        end else begin
          m_idx++;
        end
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (prev_start) begin
      m_active = 1; m_idx = 0; start_neg = cyc - 1;
    end

    check("wr_en", {31'd0, wr_en}, {31'd0, m_active});
    check("busy", {31'd0, busy}, {31'd0, m_active});
    check("done", {31'd0, done}, {31'd0, m_done});
    if (m_active) begin
      check("wr_addr", {22'd0, wr_addr}, 32'(BASE) + 32'(m_idx));
      check("wr_data", {14'd0, wr_data}, {14'd0, profile(m_idx)});
    end else if (prev_reset) begin
      check("rst_addr", {22'd0, wr_addr}, {22'd0, BASE});
      check("rst_data", {14'd0, wr_data}, 32'd0);
    end

    if (done) begin
      done_cnt++; done_neg = cyc;
    end
    if (wr_en && wr_ready && !reset) begin
      if (int'(wr_addr - BASE) < N) cap[int'(wr_addr - BASE)] = wr_data;
      acc_cnt++;
    end
    $display("cyc %0d: en=%0b rdy=%0b addr=%h data=%h busy=%0b done=%0b",
             cyc, wr_en, wr_ready, wr_addr, wr_data, busy, done);
    prev_reset = reset; prev_start = start; prev_ready = wr_ready;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin
      tick();
      n++;
    end
    if (done_cnt == 0) begin
      cmp_count++; err_count++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", limit);
    end
  endtask

  task automatic clear_run;
    acc_cnt = 0; done_cnt = 0;
    for (int i = 0; i < N; i++) cap[i] = '1;
  endtask

  task automatic check_profile(input string name);
    check({name, "_writes"}, acc_cnt, 32'd30);
    for (int i = 0; i < N; i++) check({name, "_cap"}, {14'd0, cap[i]}, {14'd0, profile(i)});
  endtask

  initial begin
    int lit_idx [8] = '{0, 1, 13, 14, 15, 16, 28, 29};
    logic [17:0] lit_val [8] = '{18'h00000, 18'h00924, 18'h076D4, 18'h08000,
                                 18'h08000, 18'h076D4, 18'h00924, 18'h00000};
    logic [9:0]  a4 [4] = '{10'h100, 10'h101, 10'h102, 10'h103};
    logic [17:0] d4 [4] = '{18'h00000, 18'h08000, 18'h08000, 18'h00000};

    reset = 1; start = 0; wr_ready = 0; start4 = 0; ready4 = 1;
    repeat (3) tick();
    reset = 0;
    tick();

    // Run 1: ready tied high, literal checks on the profile and done latency.
    clear_run();
    wr_ready = 1;
    start = 1; tick(); start = 0;
    wait_done(100);
    for (int k = 0; k < 8; k++) check("lit_data", {14'd0, cap[lit_idx[k]]}, {14'd0, lit_val[k]});
    for (int i = 0; i < N/2; i++) check("symmetry", {14'd0, cap[i]}, {14'd0, cap[N-1-i]});
    check("done_latency", done_neg - start_neg, 32'd31);
    check("run1_writes", acc_cnt, 32'd30);
    repeat (3) tick();
    check("run1_done_once", done_cnt, 32'd1);

    // Run 2: random backpressure.
    clear_run();
    wr_ready = 1'($urandom_range(0, 1));
    start = 1; tick(); start = 0;
    begin
      int n = 0;
      while (done_cnt == 0 && n < 400) begin
        wr_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
    end
    if (done_cnt == 0) begin
      cmp_count++; err_count++;
      $display("FAIL run2_timeout: got no done expected done within 400 cycles");
    end
    wr_ready = 1;
    repeat (3) tick();
    check_profile("run2");
    check("run2_done_once", done_cnt, 32'd1);

    // Run 3: start re-pulsed at beat 5, beat 29 and during DONE, then a restart two cycles after done.
    clear_run();
    start = 1; tick(); start = 0;
    for (int j = 0; j < 32; j++) begin
      start = (j == 5 || j == 29 || j == 30);
      tick();
    end
    start = 0;
    check("run3_writes", acc_cnt, 32'd30);
    check("run3_done_once", done_cnt, 32'd1);
    clear_run();
    start = 1; tick(); start = 0;
    wait_done(100);
    repeat (2) tick();
    check_profile("run3b");

    // Run 4: reset while stalled on beat 12, then restart from node 0.
    clear_run();
    start = 1; tick(); start = 0;
    repeat (12) tick();
    wr_ready = 0;
    repeat (2) tick();
    reset = 1; tick(); reset = 0;
    @(negedge clk);
    #1;
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_writes", acc_cnt, 32'd12);
    tick();
    clear_run();
    wr_ready = 1;
    start = 1; tick(); start = 0;
    @(negedge clk);
    #1;
    check("restart_addr", {22'd0, wr_addr}, 32'h0);
    check("restart_data", {14'd0, wr_data}, 32'h0);
    wait_done(100);
    repeat (2) tick();
    check_profile("run4");

    // Run 5: four-node instance at a non-zero base address.
    start4 = 1; tick(); start4 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      $display("n4 beat %0d: en=%0b addr=%h data=%h", k, wr_en4, wr_addr4, wr_data4);
      check("n4_en", {31'd0, wr_en4}, 32'd1);
      check("n4_addr", {22'd0, wr_addr4}, {22'd0, a4[k]});
      check("n4_data", {14'd0, wr_data4}, {14'd0, d4[k]});
      tick();
    end
    @(negedge clk);
    #1;
    check("n4_done", {31'd0, done4}, 32'd1);
    check("n4_en_off", {31'd0, wr_en4}, 32'd0);
    check("n4_busy_off", {31'd0, busy4}, 32'd0);
    tick();
    @(negedge clk);
    #1;
    check("n4_done_low", {31'd0, done4}, 32'd0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
